game_tick_scheduler: RTL
========================

// Module: game_tick_scheduler
// PURPOSE
//  Central timebase controller for the snake game. From the single pixel clock it issues
//  single-cycle frame_tick enables for the render/input logic, and step_req requests for
//  the snake-move logic. Step_req uses a req/ack handshake.
//  Move rate is selectable by speed level. The block sequences the game with IDLE/RUN/PAUSED.
//  Downstream logic runs on clk with enables; it does not use derived clocks.
// PARAMETERS
//  CLOCK_FREQ    74250000  input clock frequency in Hz
//  FRAME_HZ      50        frame_tick rate in Hz
//  BASE_STEP_HZ  2         step rate in Hz at level 0
//  STEP_HZ_INC   1         step rate added per speed level, in Hz
//  MAX_LVL       7         highest speed level; larger requests are clamped to this
// PORTS
//  clk         in   1  pixel clock
//  rst_n       in   1  asynchronous active-low reset
//  run_en      in   1  level; 1 = game running, 0 = return to IDLE
//  pause       in   1  level; 1 = freeze stepping while running
//  speed_lvl   in   3  requested speed level
//  speed_load  in   1  1-cycle strobe; latch speed_lvl
//  step_ack    in   1  move logic has consumed the current step
//  frame_tick  out  1  1-cycle pulse every FRAME_P cycles
//  step_req    out  1  move request; held high until acknowledged
//  overrun     out  1  sticky flag; a step period expired while step_req was still pending
//  cur_lvl     out  3  active speed level after clamping
//  state       out  2  00 IDLE, 01 RUN, 10 PAUSED
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
//  - Reset values: all outputs 0, state IDLE, both counters 0.
//  - Periods are fixed at elaboration by a constant function. No runtime divider.
//    - FRAME_P = CLOCK_FREQ/FRAME_HZ.
//    - STEP_P[l] = CLOCK_FREQ/(BASE_STEP_HZ + l*STEP_HZ_INC).
//    - Integer division, truncated; 32-bit counters.
//  - frame counter:
//    - Free-runs 0..FRAME_P-1 in every state, including IDLE.
//    - Wraps after FRAME_P-1; frame_tick is registered high for the one cycle after the wrap.
//    - Period is exactly FRAME_P cycles. First pulse is FRAME_P cycles after reset release.
//  - FSM:
//    - IDLE -> RUN when run_en=1. On this entry: step counter=0, step_req=0, overrun=0.
//    - RUN -> PAUSED when pause=1 and run_en=1.
//    - PAUSED -> RUN when pause=0. The step counter resumes from its frozen value.
//    - Any state -> IDLE when run_en=0 (highest priority). step_req drops next cycle; counter cleared.
//  - Step counter:
//    - Counts only in RUN; holds in PAUSED and IDLE.
//    - At count STEP_P[cur_lvl]-1 it wraps to 0 and raises a step event.
//    - First step_req is visible STEP_P cycles after the IDLE->RUN edge.
//  - Handshake:
//    - A step event sets step_req=1 on the next cycle.
//    - step_req stays 1 until step_ack=1 is sampled, then falls the following cycle.
//    - step_ack while step_req=0 is ignored.
//    - Step event while step_req=1 and no ack that cycle: overrun=1; the event is dropped, not queued.
//    - Step event and step_ack in the same cycle: step_req stays 1; this is a new request with no overrun.
//    - step_req is not withdrawn on entering PAUSED; an ack is still accepted while paused.
//  - Speed:
//    - speed_load latches min(speed_lvl, MAX_LVL) into cur_lvl on the next cycle.
//    - The step counter restarts from 0 in that same cycle, so the new period starts cleanly.
//    - speed_load is accepted in any state. If it coincides with a step event, the event is still issued.
//  - overrun is cleared only by reset or by IDLE->RUN entry.
// TESTING
//  Bench parameters: CLOCK_FREQ=1000, FRAME_HZ=100, BASE_STEP_HZ=2, STEP_HZ_INC=1.
//  This gives FRAME_P=10 and STEP_P=500/333/250...
//  1. Release reset, run_en=0 for 100 cycles -> 10 frame_tick pulses spaced 10 cycles apart; step_req, state, overrun stay 0.
//  2. run_en=1, ack 2 cycles after each req -> step_req rises 500 cycles after entry, then every 500; overrun=0.
//  3. Never ack -> step_req held high; overrun=1 at the second step event (1000 cycles after entry).
//     Drop run_en -> state=00 and step_req=0 next cycle; re-raise run_en -> overrun=0.
//  4. Pause at cycle 200 for 300 cycles, then release -> first step_req at entry+800.
//  5. speed_load with speed_lvl=1 at cycle 100 -> cur_lvl=1; step_req 333 cycles after the load.
//     Then speed_lvl=7 -> cur_lvl=7, STEP_P=111. Then speed_lvl=9 is impossible (3-bit port); confirm speed_lvl=7 is accepted unclamped.
//  6. Assert rst_n low mid-step_req -> all outputs 0 immediately (asynchronous), state IDLE.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// Timebase for the snake game: free-running frame_tick plus level-dependent step_req
// with a req/ack handshake, sequenced by an IDLE/RUN/PAUSED state machine.
module game_tick_scheduler #(
   parameter int unsigned CLOCK_FREQ   = 74250000,
   parameter int unsigned FRAME_HZ     = 50,
   parameter int unsigned BASE_STEP_HZ = 2,
   parameter int unsigned STEP_HZ_INC  = 1,
   parameter int unsigned MAX_LVL      = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_en,
   input  logic       pause,
   input  logic [2:0] speed_lvl,
   input  logic       speed_load,
   input  logic       step_ack,
   output logic       frame_tick,
   output logic       step_req,
   output logic       overrun,
   output logic [2:0] cur_lvl,
   output logic [1:0] state
);

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned LVL_W   = 3;
   localparam int unsigned NUM_LVL = 1 << LVL_W;
   localparam int unsigned SH_W    = $clog2(CNT_W);

   localparam logic [CNT_W-1:0] FRAME_P = CNT_W'(CLOCK_FREQ / FRAME_HZ);
   localparam logic [LVL_W-1:0] MAX_LVL_C =
      LVL_W'((MAX_LVL >= NUM_LVL) ? (NUM_LVL - 1) : MAX_LVL);

   // Step period per level, packed level-major so it can be indexed by {lvl, 0}
   function automatic logic [NUM_LVL*CNT_W-1:0] build_step_tbl();
      logic [NUM_LVL*CNT_W-1:0] tbl;
      tbl = '0;
      for (int unsigned l = 0; l < NUM_LVL; l++) begin
         tbl[l*CNT_W +: CNT_W] = CNT_W'(CLOCK_FREQ / (BASE_STEP_HZ + l * STEP_HZ_INC));
      end
      return tbl;
   endfunction

   localparam logic [NUM_LVL*CNT_W-1:0] STEP_TBL = build_step_tbl();

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10
   } state_t;

   state_t           fsm;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] step_cnt;
   logic [CNT_W-1:0] step_p_c;
   logic [LVL_W-1:0] load_lvl_c;
   logic             step_ev_c;

   assign state = fsm;

   always_comb begin
      step_p_c   = STEP_TBL[{cur_lvl, SH_W'(0)} +: CNT_W];
      load_lvl_c = (speed_lvl > MAX_LVL_C) ? MAX_LVL_C : speed_lvl;
      step_ev_c  = (fsm == ST_RUN) && (step_cnt >= step_p_c - CNT_W'(1));
   end

   // Frame divider runs in every state, independent of the game FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
      end else if (frame_cnt == FRAME_P - CNT_W'(1)) begin
         frame_cnt  <= '0;
         frame_tick <= 1'b1;
      end else begin
         frame_cnt  <= frame_cnt + CNT_W'(1);
         frame_tick <= 1'b0;
      end
   end

   // Game sequencing, step counter and step handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm      <= ST_IDLE;
         step_cnt <= '0;
         step_req <= 1'b0;
         overrun  <= 1'b0;
         cur_lvl  <= '0;
      end else begin
         if (speed_load) cur_lvl <= load_lvl_c;

         if (!run_en) begin
            fsm      <= ST_IDLE;
            step_cnt <= '0;
            step_req <= 1'b0;
         end else begin
            unique case (fsm)
               ST_IDLE: begin
                  fsm      <= ST_RUN;
                  step_cnt <= '0;
                  step_req <= 1'b0;
                  overrun  <= 1'b0;
               end
               ST_RUN, ST_PAUSED: begin
                  if (fsm == ST_RUN && pause)         fsm <= ST_PAUSED;
                  else if (fsm == ST_PAUSED && !pause) fsm <= ST_RUN;

                  // A new level restarts the period even if an event fires now
                  if (speed_load)     step_cnt <= '0;
                  else if (step_ev_c) step_cnt <= '0;
                  else if (fsm == ST_RUN) step_cnt <= step_cnt + CNT_W'(1);

                  if (step_ev_c) begin
                     if (step_req && !step_ack) overrun  <= 1'b1;
                     else                       step_req <= 1'b1;
                  end else if (step_req && step_ack) begin
                     step_req <= 1'b0;
                  end
               end
               default: fsm <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
